hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage 16-bit core. Drives hold/flush/bubble controls
//  for PC, IF/ID and ID/EX, resolving load-use hazards, EX-stage redirects (taken
//  branch, jal, jr) and data-memory stalls. The ID/EX bubble zeroes
//  dmem_wen/rf_wen/branch/jal/jr/exec at the register input.
//  Also keeps saturating stall/flush counters for performance tracking.
// PARAMETERS
//  RW           4   register-index width
//  EXTRA_FLUSH  0   extra flush cycles after a redirect (0..7; used for deeper fetch)
//  CNT_W        16  width of stall_cnt / flush_cnt
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      asynchronous reset, active-high
//  id_src1       in   RW     source reg 1 of the instruction in ID
//  id_src2       in   RW     source reg 2 of the instruction in ID
//  id_use_src2   in   1      ID instruction reads id_src2
//  idex_rdest    in   RW     destination reg of the instruction in EX
//  idex_rf_wen   in   1      EX instruction writes the register file
//  idex_mem2reg  in   1      EX instruction is a load
//  ex_redirect   in   1      EX has resolved a taken branch, jal or jr
//  mem_stall     in   1      data memory busy; the whole pipe must freeze
//  pc_hold       out  1      PC keeps its value
//  pc_redirect   out  1      PC loads the EX target this cycle
//  ifid_hold     out  1      IF/ID keeps its contents
//  ifid_flush    out  1      IF/ID loads a NOP
//  idex_hold     out  1      ID/EX keeps its contents
//  idex_bubble   out  1      ID/EX loads zeroed controls
//  stall_cnt     out  CNT_W  load-use plus mem-stall cycles, saturating
//  flush_cnt     out  CNT_W  redirect events, saturating
// BEHAVIOUR
//  - FSM states: RUN, FLUSH. Registered: state, flush counter fc[2:0], stall_cnt,
//    flush_cnt. Control outputs are combinational from state and inputs.
//  - Reset (async, while rst=1): state=RUN, fc=0, counters=0. Outputs forced to
//    pc_hold=1, ifid_flush=1, idex_bubble=1, all others 0.
//  - Priority in each cycle: rst > mem_stall > (FLUSH state) > ex_redirect > load-use.
//  - mem_stall=1: pc_hold=ifid_hold=idex_hold=1; no flush, bubble or redirect.
//    State and fc stay frozen. stall_cnt+1. A pending ex_redirect stays asserted
//    because EX is held, so it is serviced on the first cycle with mem_stall=0.
//  - FLUSH: ifid_flush=1, idex_bubble=1, pc_hold=0. fc decrements each cycle.
//    Return to RUN after the cycle in which fc==1. ex_redirect and load-use are
//    ignored in FLUSH, because bubbled stages carry no valid instruction.
//  - RUN with ex_redirect=1: pc_redirect=1, ifid_flush=1, idex_bubble=1, flush_cnt+1.
//    If EXTRA_FLUSH>0, go to FLUSH with fc=EXTRA_FLUSH; otherwise stay in RUN.
//  - Load-use = idex_mem2reg & idex_rf_wen & (idex_rdest==id_src1 |
//    (id_use_src2 & idex_rdest==id_src2)). No register is hard-wired to zero.
//    In RUN with no redirect: pc_hold=1, ifid_hold=1, idex_bubble=1, stall_cnt+1.
//    Lasts exactly 1 cycle, since the load then leaves EX. Not registered state.
//  - Otherwise all control outputs are 0 (normal advance).
//  - Invariants: hold and flush for the same stage are never both 1.
//    pc_redirect implies pc_hold=0.
//  - Counters hold at 2^CNT_W-1. They are cleared only by rst.
// TESTING
//  1 rst=1 mid-FLUSH (EXTRA_FLUSH=2) -> state RUN immediately, pc_hold=1,
//    ifid_flush=1, idex_bubble=1, counters 0; after release, outputs 0 with idle inputs.
//  2 idex_mem2reg=1, idex_rf_wen=1, idex_rdest=3, id_src1=3 -> one cycle of
//    pc_hold=ifid_hold=idex_bubble=1, stall_cnt=1. Same with id_src2=3,
//    id_use_src2=0 -> no stall.
//  3 ex_redirect=1 while load-use also true (EXTRA_FLUSH=0) -> pc_redirect=1,
//    ifid_flush=1, idex_bubble=1, ifid_hold=0, flush_cnt=1, stall_cnt unchanged.
//  4 EXTRA_FLUSH=2, ex_redirect pulse -> redirect cycle, then 2 cycles of
//    ifid_flush=idex_bubble=1 ignoring a second ex_redirect, then RUN; flush_cnt=1.
//  5 mem_stall=1 for 3 cycles with ex_redirect=1 -> all holds=1, pc_redirect=0,
//    stall_cnt=3. Cycle 4 (mem_stall=0) -> pc_redirect=1, flush_cnt=1.
//  6 CNT_W=4, 20 load-use cycles -> stall_cnt saturates at 15 and stays there.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle: pipeline status into the sequencer, stage controls and
// performance counters back out.
interface hazard_ctrl_if #(
  parameter int RW    = 4,
  parameter int CNT_W = 16
);
  logic [RW-1:0]    id_src1;
  logic [RW-1:0]    id_src2;
  logic             id_use_src2;
  logic [RW-1:0]    idex_rdest;
  logic             idex_rf_wen;
  logic             idex_mem2reg;
  logic             ex_redirect;
  logic             mem_stall;
  logic             pc_hold;
  logic             pc_redirect;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             idex_hold;
  logic             idex_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_src1, id_src2, id_use_src2, idex_rdest, idex_rf_wen, idex_mem2reg,
           ex_redirect, mem_stall,
    input  pc_hold, pc_redirect, ifid_hold, ifid_flush, idex_hold, idex_bubble,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_src1, id_src2, id_use_src2, idex_rdest, idex_rf_wen, idex_mem2reg,
           ex_redirect, mem_stall,
    output pc_hold, pc_redirect, ifid_hold, ifid_flush, idex_hold, idex_bubble,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stalls, EX redirects with
// optional extra flush cycles, data-memory freezes, and saturating perf counters.
module hazard_ctrl #(
  parameter int RW          = 4,
  parameter int EXTRA_FLUSH = 0,
  parameter int CNT_W       = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hif
);
  typedef enum logic {RUN, FLUSH} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [2:0]       EF      = 3'(EXTRA_FLUSH);

  state_e           state_q, state_d;
  logic [2:0]       fc_q, fc_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic [RW-1:0] rdest, src1, src2;
  logic          load_use;
  logic          pc_hold, pc_redirect, ifid_hold, ifid_flush, idex_hold, idex_bubble;

  assign rdest = hif.idex_rdest;
  assign src1  = hif.id_src1;
  assign src2  = hif.id_src2;

  // No register is hard-wired to zero, so r0 takes part in the compare as well.
  assign load_use = hif.idex_mem2reg & hif.idex_rf_wen &
                    ((rdest == src1) | (hif.id_use_src2 & (rdest == src2)));

  always_comb begin
    state_d     = state_q;
    fc_d        = fc_q;
    stall_d     = stall_q;
    flush_d     = flush_q;
    pc_hold     = 1'b0;
    pc_redirect = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_hold   = 1'b0;
    idex_bubble = 1'b0;
    if (rst) begin
      pc_hold     = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (hif.mem_stall) begin
      // Whole pipe frozen; a pending redirect stays visible in the held EX stage.
      pc_hold   = 1'b1;
      ifid_hold = 1'b1;
      idex_hold = 1'b1;
      if (stall_q != CNT_MAX) stall_d = stall_q + 1'b1;
    end else if (state_q == FLUSH) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      fc_d        = fc_q - 3'd1;
      if (fc_q == 3'd1) state_d = RUN;
    end else if (hif.ex_redirect) begin
      pc_redirect = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (flush_q != CNT_MAX) flush_d = flush_q + 1'b1;
      if (EF != 3'd0) begin
        state_d = FLUSH;
        fc_d    = EF;
      end
    end else if (load_use) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
      if (stall_q != CNT_MAX) stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      fc_q    <= 3'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign hif.pc_hold     = pc_hold;
  assign hif.pc_redirect = pc_redirect;
  assign hif.ifid_hold   = ifid_hold;
  assign hif.ifid_flush  = ifid_flush;
  assign hif.idex_hold   = idex_hold;
  assign hif.idex_bubble = idex_bubble;
  assign hif.stall_cnt   = stall_q;
  assign hif.flush_cnt   = flush_q;
endmodule
